// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Request, memory and writeback signals of the load/store unit.
// Handshake: a request transfers on a cycle where in_valid and in_ready are both 1;
// out_valid is a one-cycle pulse with no backpressure.
interface lsu_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic              in_load;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [31:0]       in_addr;
    logic [31:0]       in_wdata;
    logic [4:0]        in_rd;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [4:0]        out_rd;
    logic              out_fault;

    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_read_data,
        output in_ready, mem_read, mem_write, mem_address, mem_write_data,
        output out_valid, out_data, out_rd, out_fault
    );

    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
        output mem_read_data,
        input  in_ready, mem_read, mem_write, mem_address, mem_write_data,
        input  out_valid, out_data, out_rd, out_fault
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with extension, and
// sub-word store merge into the old memory word.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (funct3)
            F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU: load_data = {24'd0, byte_sel};
            F3_HU: load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merged = rdata;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = rdata;
                endcase
            end
            F3_H: merged = addr_lo[1] ? {wdata[15:0], rdata[15:0]}
                                      : {rdata[31:16], wdata[15:0]};
            F3_W: merged = wdata;
            default: merged = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: fault checks, loads, word stores, and
// two-cycle read-modify-write for byte/halfword stores.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    lsu_if.slave       bus,
    output lsu_state_t state_dbg
);
    lsu_state_t        state;
    logic [ADDR_W-1:0] rmw_addr;
    logic [31:0]       rmw_data;
    logic [4:0]        rmw_rd;

    logic        accept, fault, bad_op, illegal_f3, out_of_range, misaligned;
    logic        is_sw, go;
    logic [2:0]  f3;
    logic [31:0] load_data, merged;

    assign f3        = bus.in_funct3;
    assign accept    = bus.in_valid && (state == IDLE);
    assign state_dbg = state;

    always_comb begin
        bad_op       = (bus.in_load == bus.in_store);
        illegal_f3   = bus.in_load ? !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                                   : !(f3 inside {F3_B, F3_H, F3_W});
        out_of_range = |bus.in_addr[31:ADDR_W+2];
        misaligned   = ((f3 == F3_H || f3 == F3_HU) && bus.in_addr[0])
                     || (f3 == F3_W && bus.in_addr[1:0] != 2'b00);
        fault        = bad_op || illegal_f3 || out_of_range || misaligned;
        is_sw        = bus.in_store && (f3 == F3_W);
        go           = accept && !fault;
    end

    // In RMW_WRITE the latched word owns the memory port; otherwise the port
    // is quiet unless a legal request is being accepted.
    always_comb begin
        bus.in_ready = (state == IDLE);
        if (state == RMW_WRITE) begin
            bus.mem_read       = 1'b0;
            bus.mem_write      = 1'b1;
            bus.mem_address    = rmw_addr;
            bus.mem_write_data = rmw_data;
        end else begin
            bus.mem_read       = go && !is_sw;
            bus.mem_write      = go && is_sw;
            bus.mem_address    = accept ? bus.in_addr[ADDR_W+1:2] : '0;
            bus.mem_write_data = (go && is_sw) ? bus.in_wdata : 32'd0;
        end
    end

    lsu_align u_align (
        .funct3    (f3),
        .addr_lo   (bus.in_addr[1:0]),
        .rdata     (bus.mem_read_data),
        .wdata     (bus.in_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rmw_addr      <= '0;
            rmw_data      <= 32'd0;
            rmw_rd        <= 5'd0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 32'd0;
            bus.out_rd    <= 5'd0;
            bus.out_fault <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fault || bus.in_load || is_sw) begin
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= (!fault && bus.in_load) ? load_data : 32'd0;
                            bus.out_fault <= fault;
                            bus.out_rd    <= bus.in_rd;
                        end else begin
                            state    <= RMW_WRITE;
                            rmw_addr <= bus.in_addr[ADDR_W+1:2];
                            rmw_data <= merged;
                            rmw_rd   <= bus.in_rd;
                        end
                    end
                end
                RMW_WRITE: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= 32'd0;
                    bus.out_fault <= 1'b0;
                    bus.out_rd    <= rmw_rd;
                end
            endcase
        end
    end
endmodule
